// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Payload is zero-extended to 9 bits, the widest legal frame.
    function automatic logic par_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit baud counter: loads P-1, counts down, flags the last clk of a bit.
module uart_baud_cnt #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  bit_end_tick
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= period - PRESCALE_W'(1);
        else if (cnt != '0)
            cnt <= cnt - PRESCALE_W'(1);
    end

    assign bit_end_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: frame FSM, shift register, parity and baud timing.
module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    input  logic [PRESCALE_W-1:0] prescale_in,
    input  logic                  par_en_in,
    input  logic                  par_odd_in,
    input  logic                  two_stop_in,
    output logic                  tx_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int CNT_W = 4;

    tx_state_e             state, state_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_W-1:0]     shreg;
    logic [PRESCALE_W-1:0] p_q, p_eff, load_val;
    logic                  par_en_q, par_q, two_stop_q;
    logic                  tick, accept, last_stop, last_data, load;

    assign p_eff     = (prescale_in == '0) ? PRESCALE_W'(1) : prescale_in;
    assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));
    assign last_stop = (state == STOP) && tick && (bit_cnt == CNT_W'(two_stop_q));

    assign data_ready_out = (state == IDLE) || last_stop;
    assign accept         = data_valid_in && data_ready_out;
    assign frame_done_out = last_stop;
    assign busy_out       = (state != IDLE);

    // A new frame takes its period from the live input; later bits use the latched copy.
    assign load     = accept || (tick && (state != IDLE) && !last_stop);
    assign load_val = accept ? p_eff : p_q;

    uart_baud_cnt #(.PRESCALE_W(PRESCALE_W)) u_baud (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .period       (load_val),
        .bit_end_tick (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && last_data) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (last_stop) state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_out     <= LINE_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            p_q        <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (accept) begin
            tx_out     <= START_BIT;
            bit_cnt    <= '0;
            shreg      <= data_in;
            p_q        <= p_eff;
            par_en_q   <= par_en_in;
            par_q      <= par_calc(9'(data_in), par_odd_in);
            two_stop_q <= two_stop_in;
        end else if (tick) begin
            case (state)
                START: begin
                    tx_out  <= shreg[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (last_data) begin
                        tx_out  <= par_en_q ? par_q : STOP_BIT;
                        bit_cnt <= '0;
                    end else begin
                        tx_out  <= shreg[1];
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    tx_out  <= STOP_BIT;
                    bit_cnt <= '0;
                end
                STOP: begin
                    // Stop level equals idle level, so the line simply stays high.
                    tx_out  <= last_stop ? LINE_IDLE : STOP_BIT;
                    bit_cnt <= last_stop ? '0 : bit_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame table plus back-to-back and reset sequences.
module tb_uart_tx_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_valid_in = 1'b0;
    logic        data_ready_out;
    logic [15:0] prescale_in = 16'd1;
    logic        par_en_in = 1'b0, par_odd_in = 1'b0, two_stop_in = 1'b0;
    logic        tx_out, busy_out, frame_done_out;

    int total = 0;
    int bad   = 0;

    uart_tx_param #(.DATA_W(8), .PRESCALE_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .data_ready_out (data_ready_out),
        .prescale_in    (prescale_in),
        .par_en_in      (par_en_in),
        .par_odd_in     (par_odd_in),
        .two_stop_in    (two_stop_in),
        .tx_out         (tx_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk = ~clk;

    // seq lists the line level per bit in transmission order, first bit leftmost.
    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] prescale;
        logic        par_en;
        logic        par_odd;
        logic        two_stop;
        logic [3:0]  p;
        logic [3:0]  nbits;
        logic [11:0] seq;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_frame(input vec_t v, input string tag);
        int  len, idx;
        int  wait_cnt;
        @(negedge clk);
        data_in       = v.data;
        prescale_in   = v.prescale;
        par_en_in     = v.par_en;
        par_odd_in    = v.par_odd;
        two_stop_in   = v.two_stop;
        data_valid_in = 1'b1;
        wait_cnt = 0;
        while (!data_ready_out && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk({tag, " ready"}, 32'(data_ready_out), 32'd1);
        @(posedge clk);
        #1;
        // Scramble every frame input; the frame in flight must not notice.
        data_valid_in = 1'b0;
        data_in       = ~v.data;
        prescale_in   = v.prescale + 16'd3;
        par_en_in     = ~v.par_en;
        par_odd_in    = ~v.par_odd;
        two_stop_in   = ~v.two_stop;
        len = int'(v.p) * int'(v.nbits);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            idx = int'(v.nbits) - 1 - k / int'(v.p);
            chk({tag, " tx"}, 32'(tx_out), 32'(v.seq[idx]));
            chk({tag, " busy"}, 32'(busy_out), 32'd1);
            chk({tag, " done"}, 32'(frame_done_out), 32'(k == len - 1));
        end
        @(negedge clk);
        chk({tag, " idle busy"}, 32'(busy_out), 32'd0);
        chk({tag, " idle tx"}, 32'(tx_out), 32'd1);
        chk({tag, " idle ready"}, 32'(data_ready_out), 32'd1);
    endtask

    initial begin
        //                data   presc   pe po ts  p  n    seq
        vecs[0] = '{8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 4'd4, 4'd10, 12'b0101001011};
        vecs[1] = '{8'hA5, 16'd2, 1'b1, 1'b0, 1'b0, 4'd2, 4'd11, 12'b01010010101};
        vecs[2] = '{8'hA5, 16'd2, 1'b1, 1'b1, 1'b0, 4'd2, 4'd11, 12'b01010010111};
        vecs[3] = '{8'h00, 16'd5, 1'b0, 1'b0, 1'b1, 4'd5, 4'd11, 12'b00000000011};
        vecs[4] = '{8'h3C, 16'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd10, 12'b0001111001};
        vecs[5] = '{8'h01, 16'd1, 1'b1, 1'b1, 1'b1, 4'd1, 4'd12, 12'b010000000011};

        #12;
        chk("reset tx", 32'(tx_out), 32'd1);
        chk("reset busy", 32'(busy_out), 32'd0);
        chk("reset done", 32'(frame_done_out), 32'd0);
        chk("reset ready", 32'(data_ready_out), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++)
            send_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: valid held high, second payload taken in the final stop clk.
        begin
            logic [19:0] seq2;
            int          dones;
            seq2  = 20'b0100000001_0000000011;
            dones = 0;
            @(negedge clk);
            data_in = 8'h01; prescale_in = 16'd3;
            par_en_in = 1'b0; par_odd_in = 1'b0; two_stop_in = 1'b0;
            data_valid_in = 1'b1;
            @(posedge clk);
            #1 data_in = 8'h80;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (k == 30) data_valid_in = 1'b0;
                chk("b2b tx", 32'(tx_out), 32'(seq2[19 - k / 3]));
                chk("b2b busy", 32'(busy_out), 32'd1);
                chk("b2b done", 32'(frame_done_out), 32'(k == 29 || k == 59));
                chk("b2b ready", 32'(data_ready_out), 32'(k == 29 || k == 59));
                if (frame_done_out) dones++;
            end
            chk("b2b done count", 32'(dones), 32'd2);
            @(negedge clk);
            chk("b2b end busy", 32'(busy_out), 32'd0);
        end

        // Reset during data bit 3 of a 0x55 frame at P=2.
        begin
            logic done_seen;
            done_seen = 1'b0;
            @(negedge clk);
            data_in = 8'h55; prescale_in = 16'd2;
            par_en_in = 1'b0; par_odd_in = 1'b0; two_stop_in = 1'b0;
            data_valid_in = 1'b1;
            @(posedge clk);
            #1 data_valid_in = 1'b0;
            for (int k = 0; k <= 8; k++) begin
                @(negedge clk);
                if (frame_done_out) done_seen = 1'b1;
            end
            chk("pre-reset busy", 32'(busy_out), 32'd1);
            chk("pre-reset tx d3", 32'(tx_out), 32'd0);
            reset_n = 1'b0;
            #1;
            chk("mid reset tx", 32'(tx_out), 32'd1);
            chk("mid reset busy", 32'(busy_out), 32'd0);
            chk("mid reset done", 32'(frame_done_out), 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (frame_done_out) done_seen = 1'b1;
                if (busy_out) done_seen = 1'b1;
            end
            chk("no done after abort", 32'(done_seen), 32'd0);
            send_frame('{8'h55, 16'd3, 1'b0, 1'b0, 1'b0, 4'd3, 4'd10, 12'b0101010101}, "post-reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
